vector_list_player: RTL and testbench

//  Walks a vector-list ROM (entries {x, y, line, pos}) from a start address.

---
 rtl/vector_list_player.sv | 162 ++++++++++++++++
 tb/tb_vector_list_player.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_list_player.sv
// Vector-list player: walks a ROM of {x, y, line, pos} entries from a latched base
// and hands each vector to the line drawer over a valid/ready handshake.
module vector_list_player #(
  parameter int unsigned ADDRESSWIDTH = 6,
  parameter int unsigned COORDW       = 8,
  parameter int unsigned DATAWIDTH    = 2*COORDW+2,
  parameter int unsigned ROM_LAT      = 0,
  parameter int unsigned MAX_ENTRIES  = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDRESSWIDTH-1:0] base_addr,
  input  logic                    loop_en,
  input  logic                    stop,
  output logic [ADDRESSWIDTH-1:0] rom_addr,
  input  logic [DATAWIDTH-1:0]    rom_data,
  output logic                    vec_valid,
  input  logic                    vec_ready,
  output logic [COORDW-1:0]       vec_x,
  output logic [COORDW-1:0]       vec_y,
  output logic                    vec_draw,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [7:0]              frame_cnt
);

  localparam int unsigned CNTW = $clog2(MAX_ENTRIES + 1);

  // Decode is folded into the capture edge so PRESENT directly follows FETCH/WAIT.
  typedef enum logic [1:0] {IDLE, FETCH, WAIT, PRESENT} state_t;

  state_t                  state;
  logic [ADDRESSWIDTH-1:0] base_q;
  logic [CNTW-1:0]         entry_cnt;
  logic [1:0]              wait_cnt;
  logic                    eol_q;
  logic                    stop_seen;

  logic [1:0] code;
  logic       capture;
  logic       handshake;
  logic       boundary;
  logic       at_eol;
  logic       stop_now;
  logic       overrun;

  assign code = rom_data[1:0];

  // Entry is valid ROM_LAT clocks after rom_addr was set.
  always_comb begin
    capture = 1'b0;
    if (state == FETCH) begin
      capture = (ROM_LAT == 0);
    end else if (state == WAIT) begin
      capture = (wait_cnt == 2'(ROM_LAT));
    end
  end

  // A boundary is where the next step is chosen: after a handshake or on a 00 entry.
  assign handshake = (state == PRESENT) && vec_valid && vec_ready;
  assign boundary  = handshake || (capture && (code == 2'b00));
  assign at_eol    = handshake ? eol_q : 1'b1;
  assign stop_now  = stop_seen || stop;
  assign overrun   = (entry_cnt == CNTW'(MAX_ENTRIES)) ||
                     (rom_addr == {ADDRESSWIDTH{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      base_q    <= '0;
      rom_addr  <= '0;
      entry_cnt <= '0;
      wait_cnt  <= '0;
      eol_q     <= 1'b0;
      stop_seen <= 1'b0;
      vec_valid <= 1'b0;
      vec_x     <= '0;
      vec_y     <= '0;
      vec_draw  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      frame_cnt <= '0;
    end else begin
      done <= 1'b0;
      if ((state != IDLE) && stop) begin
        stop_seen <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            base_q    <= base_addr;
            rom_addr  <= base_addr;
            err       <= 1'b0;
            frame_cnt <= '0;
            entry_cnt <= '0;
            stop_seen <= 1'b0;
            busy      <= 1'b1;
            state     <= FETCH;
          end
        end
        FETCH: begin
          if (ROM_LAT != 0) begin
            wait_cnt <= 2'd1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (!capture) begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        PRESENT: ;
        default: state <= IDLE;
      endcase

      if (capture) begin
        entry_cnt <= entry_cnt + CNTW'(1);
        if (code != 2'b00) begin
          vec_x     <= rom_data[DATAWIDTH-1 -: COORDW];
          vec_y     <= rom_data[2 +: COORDW];
          vec_draw  <= code[1];
          eol_q     <= &code;
          vec_valid <= 1'b1;
          state     <= PRESENT;
        end
      end

      // Priority: stop, then end-of-list, then overrun, then next entry.
      if (boundary) begin
        vec_valid <= 1'b0;
        stop_seen <= 1'b0;
        if (stop_now) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else if (at_eol) begin
          done      <= 1'b1;
          frame_cnt <= frame_cnt + 8'd1;
          if (loop_en) begin
            rom_addr  <= base_q;
            entry_cnt <= '0;
            state     <= FETCH;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end else if (overrun) begin
          err   <= 1'b1;
          state <= IDLE;
          busy  <= 1'b0;
        end else begin
          rom_addr <= rom_addr + ADDRESSWIDTH'(1);
          state    <= FETCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_list_player.sv
// Bench for vector_list_player: six instances (ROM_LAT 0/1/2 x MAX_ENTRIES 64/4) share
// stimulus; a list-walking reference model predicts vectors, done, err and frame_cnt.
module tb_vector_list_player;

  localparam int NI = 6;
  localparam int D  = 4096;

  logic clk;
  logic rst_n, start, stop, loop_en, vec_ready;
  logic [5:0] base_addr;

  logic [5:0]    rom_addr [NI];
  logic [17:0]   rom_data [NI];
  logic [7:0]    vec_x [NI];
  logic [7:0]    vec_y [NI];
  logic [7:0]    frame_cnt [NI];
  logic [NI-1:0] vec_valid, vec_draw, busy, done, err;

  logic [17:0] rom [64];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned LAT = g % 3;
    localparam int unsigned MAX = (g < 3) ? 64 : 4;
    logic [17:0] p1, p2;
    always @(posedge clk) begin
      p1 <= rom[rom_addr[g]];
      p2 <= p1;
    end
    assign rom_data[g] = (LAT == 0) ? rom[rom_addr[g]] : (LAT == 1) ? p1 : p2;

    vector_list_player #(
      .ADDRESSWIDTH(6), .COORDW(8), .ROM_LAT(LAT), .MAX_ENTRIES(MAX)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .loop_en(loop_en), .stop(stop), .rom_addr(rom_addr[g]), .rom_data(rom_data[g]),
      .vec_valid(vec_valid[g]), .vec_ready(vec_ready), .vec_x(vec_x[g]),
      .vec_y(vec_y[g]), .vec_draw(vec_draw[g]), .busy(busy[g]), .done(done[g]),
      .err(err[g]), .frame_cnt(frame_cnt[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: records accepted vectors, done pulses and hold violations per instance.
  int          cyc = 0;
  logic [16:0] obs [NI][D];
  int          obs_n [NI]     = '{default: 0};
  int          done_n [NI]    = '{default: 0};
  int          hold_err [NI]  = '{default: 0};
  int          hs_cyc [NI]    = '{default: 0};
  int          done_cyc [NI]  = '{default: 0};
  logic [5:0]  done_addr [NI] = '{default: '0};
  logic        prev_wait [NI] = '{default: 1'b0};
  logic [16:0] held [NI]      = '{default: '0};

  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        prev_wait[i] <= 1'b0;
      end else begin
        if (prev_wait[i] && (!vec_valid[i] || {vec_draw[i], vec_x[i], vec_y[i]} !== held[i]))
          hold_err[i] <= hold_err[i] + 1;
        if (vec_valid[i] && vec_ready) begin
          obs[i][obs_n[i] % D] <= {vec_draw[i], vec_x[i], vec_y[i]};
          obs_n[i]  <= obs_n[i] + 1;
          hs_cyc[i] <= cyc;
        end
        prev_wait[i] <= vec_valid[i] && !vec_ready;
        held[i]      <= {vec_draw[i], vec_x[i], vec_y[i]};
        if (done[i]) begin
          done_n[i]    <= done_n[i] + 1;
          done_cyc[i]  <= cyc;
          done_addr[i] <= rom_addr[i];
        end
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;
  int phase = 0;
  int sn [NI], sd [NI], sh [NI], pd [NI], pn [NI];

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic logic [17:0] mk(input logic [7:0] x, input logic [7:0] y,
                                     input logic [1:0] c);
    return {x, y, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       vec_ready = 1'b1;
      1:       vec_ready = (phase % 3 == 0);
      2:       vec_ready = ($urandom_range(0, 1) != 0);
      default: vec_ready = 1'b0;
    endcase
    phase++;
  endtask

  task automatic snap();
    for (int i = 0; i < NI; i++) begin
      sn[i] = obs_n[i];
      sd[i] = done_n[i];
      sh[i] = hold_err[i];
    end
  endtask

  task automatic go(input int b, input bit with_stop, input string tag);
    snap();
    base_addr = 6'(b);
    start = 1'b1;
    stop = with_stop;
    tick();
    start = 1'b0;
    stop = 1'b0;
    chk({tag, "_accept_busy"}, 32'(busy), 32'(6'h3f));
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    tick();
    while ((|busy) && n < 5000) begin
      tick();
      n++;
    end
    chk({tag, "_idle_timeout"}, 32'(|busy), 32'd0);
    tick();
    tick();
  endtask

  // Reference: walk the list from base with the instance's entry limit.
  task automatic check_run(input string tag, input int base, input int lo, input int hi);
    int addr, cnt, k, got, mx;
    bit fin, xd, xe;
    logic [17:0] e;
    for (int i = lo; i <= hi; i++) begin
      addr = base; cnt = 0; k = 0; fin = 0; xd = 0; xe = 0;
      mx = (i < 3) ? 64 : 4;
      got = obs_n[i] - sn[i];
      while (!fin) begin
        e = rom[addr];
        cnt++;
        if (e[1:0] == 2'b00) begin
          xd = 1; fin = 1;
        end else begin
          if (k < got)
            chk($sformatf("%s_vec%0d_i%0d", tag, k, i), 32'(obs[i][(sn[i] + k) % D]),
                32'({e[1], e[17:10], e[9:2]}));
          k++;
          if (e[1:0] == 2'b11) begin
            xd = 1; fin = 1;
          end else if (cnt == mx || addr == 63) begin
            xe = 1; fin = 1;
          end else begin
            addr++;
          end
        end
      end
      chk($sformatf("%s_count_i%0d", tag, i), 32'(got), 32'(k));
      chk($sformatf("%s_done_i%0d", tag, i), 32'(done_n[i] - sd[i]), 32'(xd));
      chk($sformatf("%s_err_i%0d", tag, i), 32'(err[i]), 32'(xe));
      chk($sformatf("%s_frame_i%0d", tag, i), 32'(frame_cnt[i]), 32'(xd));
      chk($sformatf("%s_busy_i%0d", tag, i), 32'(busy[i]), 32'd0);
      chk($sformatf("%s_hold_i%0d", tag, i), 32'(hold_err[i] - sh[i]), 32'd0);
    end
  endtask

  task automatic lay_list();
    rom[42] = mk(8'd0,   8'd255, 2'b01);
    rom[43] = mk(8'd0,   8'd0,   2'b10);
    rom[44] = mk(8'd255, 8'd0,   2'b10);
    rom[45] = mk(8'd255, 8'd255, 2'b10);
    rom[46] = mk(8'd0,   8'd255, 2'b10);
    rom[47] = mk(8'd0,   8'd255, 2'b11);
  endtask

  initial begin
    int n, f, cnt, b, len, term;
    logic [1:0] c;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    vec_ready = 1'b0; base_addr = '0;
    for (int a = 0; a < 64; a++) rom[a] = mk(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)));

    // Reset state
    tick(); tick();
    chk("rst_valid", 32'(vec_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done_err", 32'({done, err}), 32'd0);
    chk("rst_addr0", 32'(rom_addr[0]), 32'd0);
    chk("rst_frame0", 32'(frame_cnt[0]), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: basic list at 42, ready always high
    lay_list();
    rdy_mode = 0;
    go(42, 1'b0, "t1");
    wait_idle("t1");
    check_run("t1", 42, 0, NI - 1);
    for (int k = 0; k < 6; k++)
      chk($sformatf("t1_draw%0d", k), 32'(obs[0][(sn[0] + k) % D][16]), 32'(k != 0));
    for (int i = 0; i < 3; i++)
      chk($sformatf("t1_done_lat_i%0d", i), 32'(done_cyc[i] - hs_cyc[i]), 32'd1);

    // 2: ready one clock in three; a start while busy must be ignored
    rdy_mode = 1;
    go(42, 1'b0, "t2");
    tick(); tick(); tick();
    base_addr = 6'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle("t2");
    check_run("t2", 42, 0, NI - 1);

    // 3: looped refresh, then stop mid-pass
    rdy_mode = 0;
    loop_en = 1'b1;
    go(42, 1'b0, "t3");
    n = 0;
    while (!((done_n[0] - sd[0] >= 3) && (done_n[1] - sd[1] >= 3) && (done_n[2] - sd[2] >= 3))
           && n < 3000) begin
      tick();
      n++;
    end
    chk("t3_loop_timeout", 32'(n < 3000), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int i = 0; i < NI; i++) begin
      pd[i] = done_n[i];
      pn[i] = obs_n[i];
    end
    wait_idle("t3");
    loop_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      f = done_n[i] - sd[i];
      cnt = obs_n[i] - sn[i];
      chk($sformatf("t3_frame_i%0d", i), 32'(frame_cnt[i]), 32'(f));
      chk($sformatf("t3_passes_i%0d", i), 32'(f >= 3), 32'd1);
      chk($sformatf("t3_nodone_after_stop_i%0d", i), 32'(done_n[i]), 32'(pd[i]));
      chk($sformatf("t3_one_more_i%0d", i), 32'(obs_n[i] - pn[i] <= 1), 32'd1);
      chk($sformatf("t3_reload_addr_i%0d", i), 32'(done_addr[i]), 32'd42);
      chk($sformatf("t3_err_i%0d", i), 32'(err[i]), 32'd0);
      chk($sformatf("t3_veccount_i%0d", i), 32'(cnt >= f * 6 && cnt <= f * 6 + 6), 32'd1);
      for (int k = 0; k < cnt && k < D; k++)
        chk($sformatf("t3_vec%0d_i%0d", k, i), 32'(obs[i][(sn[i] + k) % D]),
            32'({rom[42 + k % 6][1], rom[42 + k % 6][17:10], rom[42 + k % 6][9:2]}));
    end
    check_run("t3", 42, 3, NI - 1);

    // 4: all-zero entry terminates without a vector
    rom[44] = '0;
    go(42, 1'b0, "t4");
    wait_idle("t4");
    check_run("t4", 42, 0, NI - 1);

    // 5: no terminator from 0; overrun, then next start clears err
    for (int a = 0; a < 64; a++) rom[a] = mk(8'($urandom), 8'($urandom), 2'($urandom_range(1, 2)));
    rdy_mode = 2;
    go(0, 1'b0, "t5");
    wait_idle("t5");
    check_run("t5", 0, 0, NI - 1);
    rom[2] = mk(8'd7, 8'd9, 2'b11);
    go(0, 1'b0, "t5b");
    chk("t5_err_cleared", 32'(err), 32'd0);
    wait_idle("t5b");
    check_run("t5b", 0, 0, NI - 1);

    // 6: last address non-terminal, no wrap
    go(63, 1'b0, "t6");
    wait_idle("t6");
    check_run("t6", 63, 0, NI - 1);

    // Reset while vectors are being presented
    lay_list();
    rdy_mode = 3;
    go(42, 1'b0, "t6r");
    n = 0;
    while (!(&vec_valid) && n < 100) begin
      tick();
      n++;
    end
    chk("t6r_present_timeout", 32'(&vec_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6r_async_valid", 32'(vec_valid), 32'd0);
    chk("t6r_async_busy", 32'(busy), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    rdy_mode = 0;
    tick();
    chk("t6r_addr0", 32'(rom_addr[0]), 32'd0);
    chk("t6r_err_frame", 32'({err, frame_cnt[0]}), 32'd0);

    // stop while idle does nothing
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    chk("idle_stop_busy", 32'(busy), 32'd0);

    // Randomized lists; trial 0 raises start and stop together
    for (int t = 0; t < 12; t++) begin
      b = $urandom_range(0, 63);
      len = $urandom_range(1, 10);
      term = $urandom_range(0, 2);
      for (int j = 0; j < len; j++) begin
        if (b + j <= 63) begin
          if (j == len - 1 && term == 0) c = 2'b11;
          else if (j == len - 1 && term == 1) c = 2'b00;
          else c = 2'($urandom_range(1, 2));
          rom[b + j] = mk(8'($urandom), 8'($urandom), c);
        end
      end
      rdy_mode = $urandom_range(0, 2);
      go(b, t == 0, $sformatf("r%0d", t));
      wait_idle($sformatf("r%0d", t));
      check_run($sformatf("r%0d", t), b, 0, NI - 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
